// File: rtl/event_logger_pkg.sv
// ---------------------------------------------------------------------------
// event_logger_pkg : shared defaults and record layout for the event logger
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package event_logger_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_TS_W   = 16;
    localparam int DEF_DEPTH  = 8;

    localparam int REC_W   = DEF_TS_W + 2 * DEF_NUM_CH;
    localparam int LVL_LSB = 0;

    // Record layout, MSB to LSB: {timestamp, changed mask, levels}
    function automatic int rec_width(input int ts_w, input int num_ch);
        return ts_w + 2 * num_ch;
    endfunction

    function automatic int chg_lsb(input int num_ch);
        return num_ch;
    endfunction

    function automatic int ts_lsb(input int num_ch);
        return 2 * num_ch;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo : first-word-fall-through FIFO with registered head output
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic                       rd_valid,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    next_rd;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    next_cnt;
    logic [WIDTH-1:0] head;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign next_rd = do_pop ? rd_ptr + AW'(1) : rd_ptr;

    always_comb begin
        next_cnt = cnt;
        case ({do_push, do_pop})
            2'b10:   next_cnt = cnt + CW'(1);
            2'b01:   next_cnt = cnt - CW'(1);
            default: next_cnt = cnt;
        endcase
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // The head register tracks whichever slot will be at the front after this
    // edge; when that slot is being written right now, take the incoming data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            head   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= next_rd;
            cnt    <= next_cnt;
            if (next_cnt != '0) begin
                head <= (do_push && (next_rd == wr_ptr)) ? wr_data : mem[next_rd];
            end
        end
    end

    assign rd_valid = !empty;
    assign rd_data  = head;
    assign count    = cnt;

endmodule

`default_nettype wire

// File: rtl/event_timestamp_logger.sv
// ---------------------------------------------------------------------------
// event_timestamp_logger : timestamps channel changes and queues them as records
// Optional INPUT_SYNC_EN adds a 2-flop synchronizer per channel.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module event_timestamp_logger
    import event_logger_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int TS_W   = DEF_TS_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic [NUM_CH-1:0]          ev_in,
    input  logic                       ovf_clear,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [TS_W-1:0]            rd_ts,
    output logic [NUM_CH-1:0]          rd_changed,
    output logic [NUM_CH-1:0]          rd_level,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int RW      = rec_width(TS_W, NUM_CH);
    localparam int TS_OFF  = ts_lsb(NUM_CH);
    localparam int CHG_OFF = chg_lsb(NUM_CH);

    logic [NUM_CH-1:0] det_in;
    logic [NUM_CH-1:0] prev_in;
    logic [NUM_CH-1:0] change;
    logic [TS_W-1:0]   ts_cnt;
    logic [RW-1:0]     rec;
    logic [RW-1:0]     rd_data;
    logic              push;
    logic              pop;
    logic              full;
    logic              drop;

`ifdef INPUT_SYNC_EN
    logic [NUM_CH-1:0] sync_1;
    logic [NUM_CH-1:0] sync_2;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= ev_in;
            sync_2 <= sync_1;
        end
    end

    assign det_in = sync_2;
`else
    assign det_in = ev_in;
`endif

    // prev_in follows the input even when disabled so that disabled-period
    // changes are absorbed rather than logged once enable returns.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt  <= '0;
            prev_in <= '0;
        end else begin
            prev_in <= det_in;
            if (enable) begin
                ts_cnt <= ts_cnt + TS_W'(1);
            end
        end
    end

    assign change = det_in ^ prev_in;
    assign push   = enable && (change != '0);
    assign rec    = {ts_cnt, change, det_in};
    assign pop    = rd_valid && rd_ready;
    assign drop   = push && full && !pop;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clear) begin
            overflow <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (push),
        .wr_data  (rec),
        .pop      (pop),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .count    (count),
        .full     (full)
    );

    assign rd_ts      = rd_data[TS_OFF  +: TS_W];
    assign rd_changed = rd_data[CHG_OFF +: NUM_CH];
    assign rd_level   = rd_data[LVL_LSB +: NUM_CH];

endmodule

`default_nettype wire
